// File: rtl/axis_nco_sweep.sv
// Frequency sweep generator: streams NCO phase steps from start to stop
// with optional dwell gaps, single-shot or continuous.
module axis_nco_sweep #(
  parameter int STEP_WIDTH  = 32,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   aclk,
  input  logic                   arst_n,
  input  logic [STEP_WIDTH-1:0]  cfg_start_step,
  input  logic [STEP_WIDTH-1:0]  cfg_stop_step,
  input  logic [STEP_WIDTH-1:0]  cfg_delta,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic                   cfg_continuous,
  input  logic                   start,
  input  logic                   abort,
  output logic [STEP_WIDTH-1:0]  m_axis_data_tdata,
  output logic                   m_axis_data_tvalid,
  input  logic                   m_axis_data_tready,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            sweep_count
);

  typedef enum logic [1:0] {IDLE, EMIT, DWELL} state_t;

  state_t                 state;
  logic [STEP_WIDTH-1:0]  cur;
  logic [STEP_WIDTH-1:0]  start_q;
  logic [STEP_WIDTH-1:0]  stop_q;
  logic [STEP_WIDTH-1:0]  delta_q;
  logic [DWELL_WIDTH-1:0] dwell_q;
  logic [DWELL_WIDTH-1:0] dwell_cnt;
  logic                   cont_q;
  logic                   last_q;

  logic [STEP_WIDTH:0]    sum;
  logic [STEP_WIDTH-1:0]  nxt;
  logic                   hs;
  logic                   is_last;
  logic                   fin;

  // Extra bit catches the carry; carry or overshoot saturates to stop.
  assign sum     = {1'b0, cur} + {1'b0, delta_q};
  assign nxt     = (sum > {1'b0, stop_q}) ? stop_q : sum[STEP_WIDTH-1:0];
  assign hs      = m_axis_data_tvalid & m_axis_data_tready;
  assign is_last = (cur >= stop_q);

  assign fin = (state == EMIT && hs && is_last && dwell_q == '0)
            || (state == DWELL && dwell_cnt == 1 && last_q);

  assign m_axis_data_tdata = cur;

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state              <= IDLE;
      cur                <= '0;
      start_q            <= '0;
      stop_q             <= '0;
      delta_q            <= '0;
      dwell_q            <= '0;
      dwell_cnt          <= '0;
      cont_q             <= 1'b0;
      last_q             <= 1'b0;
      m_axis_data_tvalid <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      sweep_count        <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state              <= IDLE;
        m_axis_data_tvalid <= 1'b0;
        busy               <= 1'b0;
      end else if (fin) begin
        sweep_count <= sweep_count + 16'd1;
        last_q      <= 1'b0;
        if (cont_q) begin
          cur                <= start_q;
          state              <= EMIT;
          m_axis_data_tvalid <= 1'b1;
        end else begin
          done               <= 1'b1;
          state              <= IDLE;
          m_axis_data_tvalid <= 1'b0;
          busy               <= 1'b0;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              start_q            <= cfg_start_step;
              stop_q             <= cfg_stop_step;
              delta_q            <= cfg_delta;
              dwell_q            <= cfg_dwell;
              cont_q             <= cfg_continuous;
              cur                <= cfg_start_step;
              last_q             <= 1'b0;
              state              <= EMIT;
              m_axis_data_tvalid <= 1'b1;
              busy               <= 1'b1;
            end
          end
          EMIT: begin
            if (hs) begin
              last_q <= is_last;
              if (!is_last) cur <= nxt;
              if (dwell_q != '0) begin
                state              <= DWELL;
                dwell_cnt          <= dwell_q;
                m_axis_data_tvalid <= 1'b0;
              end
            end
          end
          DWELL: begin
            if (dwell_cnt == 1) begin
              state              <= EMIT;
              m_axis_data_tvalid <= 1'b1;
            end else begin
              dwell_cnt <= dwell_cnt - 1'b1;
            end
          end
          default: begin
            state              <= IDLE;
            m_axis_data_tvalid <= 1'b0;
            busy               <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/axis_nco_sweep.md
AXIS_NCO_SWEEP -- requirements
Module: axis_nco_sweep

Interface
REQ-001 The module SHALL have parameter STEP_WIDTH, default 32, giving the width of an NCO phase step (8 integer + 24 fractional bits).
REQ-002 The module SHALL have parameter DWELL_WIDTH, default 16, giving the width of the dwell counter.
REQ-003 The module SHALL have port aclk, input, 1 bit: the single clock; all logic is rising-edge on aclk.
REQ-004 The module SHALL have port arst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port cfg_start_step, input, STEP_WIDTH bits: first step of the sweep.
REQ-006 The module SHALL have port cfg_stop_step, input, STEP_WIDTH bits: last step of the sweep.
REQ-007 The module SHALL have port cfg_delta, input, STEP_WIDTH bits: unsigned increment between beats.
REQ-008 The module SHALL have port cfg_dwell, input, DWELL_WIDTH bits: idle cycles inserted after each accepted beat.
REQ-009 The module SHALL have port cfg_continuous, input, 1 bit: 1 = restart at start after the stop beat; 0 = single sweep.
REQ-010 The module SHALL have port start, input, 1 bit: single-cycle request to begin a sweep.
REQ-011 The module SHALL have port abort, input, 1 bit: terminates any sweep in progress.
REQ-012 The module SHALL have port m_axis_data_tdata, output, STEP_WIDTH bits: step value, intended to drive the NCO step input.
REQ-013 The module SHALL have ports m_axis_data_tvalid (output, 1 bit) and m_axis_data_tready (input, 1 bit): AXI-Stream handshake.
REQ-014 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 The module SHALL have port done, output, 1 bit: one-cycle pulse when a single sweep completes.
REQ-016 The module SHALL have port sweep_count, output, 16 bits: number of completed sweeps, wrapping modulo 2^16.

Function
REQ-017 The FSM SHALL have states IDLE, EMIT and DWELL; tvalid SHALL be 1 only in EMIT.
REQ-018 In IDLE, start=1 SHALL latch all cfg_* inputs, load cur=cfg_start_step and enter EMIT; tvalid=1 with tdata=start_step SHALL appear on the next cycle.
REQ-019 cfg_* changes during a sweep SHALL have no effect until the next start.
REQ-020 In EMIT, tdata=cur SHALL be held stable until the handshake (tvalid & tready).
REQ-021 On the handshake, the next step SHALL be computed in STEP_WIDTH+1 bits as cur+delta; if that carries or exceeds stop, next SHALL be stop (saturation).
REQ-022 If the accepted beat equals stop it is the final beat; otherwise cur SHALL become next.
REQ-023 After the handshake, if latched dwell>0 the FSM SHALL enter DWELL for exactly dwell cycles with tvalid=0, then return to EMIT; if dwell=0 it SHALL stay in EMIT, giving back-to-back beats.
REQ-024 After the final beat and its dwell, sweep_count SHALL increment by 1.
REQ-025 After the final beat and its dwell with cfg_continuous=1, cur SHALL reload to start and the FSM SHALL re-enter EMIT.
REQ-026 After the final beat and its dwell with cfg_continuous=0, done SHALL pulse for 1 cycle and the FSM SHALL enter IDLE.
REQ-027 If start_step >= stop_step, the sweep SHALL consist of one beat carrying start_step, which is treated as final.
REQ-028 If delta=0 and start<stop, cur SHALL repeat indefinitely; this is legal and only abort ends it.
REQ-029 abort=1 in any state SHALL force IDLE on the next edge with tvalid=0; done SHALL NOT pulse and sweep_count SHALL NOT change.
REQ-030 abort is permitted to retract tvalid without a handshake, as the single exception to the AXI-Stream hold rule.
REQ-031 If abort and a handshake occur in the same cycle, the beat counts as transferred and abort still wins.
REQ-032 If start and abort are both 1 in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-033 start outside IDLE SHALL be ignored.

Reset
REQ-034 arst_n=0 SHALL immediately force IDLE, tdata=0, tvalid=0, busy=0, done=0, sweep_count=0, and clear the dwell counter and cur.
REQ-035 Reset asserted mid-sweep SHALL discard the sweep with no done pulse.
REQ-036 After reset release, the first start SHALL be honoured on the first rising edge.

Verification
REQ-037 Single sweep: start=0x100, stop=0x400, delta=0x100, dwell=0, tready=1 -> beats 0x100, 0x200, 0x300, 0x400 on consecutive cycles; done 1 cycle later; sweep_count=1.
REQ-038 Saturation and dwell: start=0x100, stop=0x350, delta=0x100, dwell=3 -> beats 0x100, 0x200, 0x300, 0x350, each followed by 3 tvalid=0 cycles.
REQ-039 Backpressure: tready toggled randomly -> tdata stable while tvalid & !tready; sequence identical to REQ-037.
REQ-040 Continuous: cfg_continuous=1 with the REQ-037 configuration -> the 0x100 beat follows the 0x400 beat; sweep_count increments each wrap; no done pulse.
REQ-041 Overflow: start=0xFFFFFF00, stop=0xFFFFFFFF, delta=0x80 -> beats 0xFFFFFF00, 0xFFFFFF80, 0xFFFFFFFF, then done.
REQ-042 Abort and reset: abort during DWELL of the second beat -> tvalid=0 and busy=0 next cycle, no done, sweep_count unchanged; same check with arst_n pulsed low mid-EMIT.
